// File: rtl/music_player_pkg.sv
// Shared widths, state encoding and sample-selection helper for the flash-backed
// audio sequencer.
package music_player_pkg;

  localparam int ADDR_W       = 23;
  localparam int WORD_W       = 32;
  localparam int SAMPLE_W     = 16;
  localparam int BUSY_TIMEOUT = 16;
  localparam int TMO_W        = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    WAIT_BUSY,
    WAIT_DATA,
    PLAY_A,
    PLAY_B
  } mp_state_t;

  // Forward words play low half first; backward words play high half first.
  function automatic logic [SAMPLE_W-1:0] sample_sel(
    input logic [WORD_W-1:0] word,
    input logic              fwd,
    input logic              second
  );
    return (fwd ^ second) ? word[SAMPLE_W-1:0] : word[WORD_W-1:SAMPLE_W];
  endfunction

endpackage

// File: rtl/music_player_tick_sync.sv
// Brings the sample-rate square wave into the system clock domain and turns
// each rising edge into a single-cycle tick.
module tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic tick_o
);

  logic meta_q, sync_q, prev_q, tick_q;
  logic tick_d;

  assign tick_d = sync_q & ~prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/music_player.sv
// Sample sequencer: fetches 32-bit words from the flash read controller and
// plays them out as two 16-bit samples, walking the song region in either direction.
module music_player
  import music_player_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FIRST_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = 23'h07FFFF
) (
  input  logic                CLK_50M,
  input  logic                Rst,
  input  logic                CLK_22K,
  input  logic [ADDR_W-1:0]   InitialAddress,
  input  logic                Direction,
  input  logic                Pause,
  output logic [SAMPLE_W-1:0] AudioData,
  output logic                Terminate,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic                Read,
  input  logic [WORD_W-1:0]   DATA,
  input  logic                Busy,
  input  logic                Error
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  logic tick;

  tick_sync u_tick_sync (
    .clk_i  (CLK_50M),
    .rst_ni (Rst),
    .async_i(CLK_22K),
    .tick_o (tick)
  );

  mp_state_t           state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d;
  logic                wdir_q, wdir_d;
  logic                read_q, read_d;
  logic                term_q, term_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                play_step;

  // Pause only freezes the playback steps; fetching carries on regardless.
  assign play_step = tick & ~Pause;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    audio_d = audio_q;
    wdir_d  = wdir_q;
    read_d  = 1'b0;
    term_d  = 1'b0;
    tmo_d   = tmo_q;
    unique case (state_q)
      INIT: begin
        addr_d  = InitialAddress;
        state_d = FETCH;
      end
      FETCH: begin
        if (!Busy) begin
          read_d  = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (Busy) begin
          state_d = WAIT_DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FETCH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DATA: begin
        if (!Busy) begin
          word_d  = Error ? '0 : DATA;
          wdir_d  = Direction;
          state_d = PLAY_A;
        end
      end
      PLAY_A: begin
        if (play_step) begin
          audio_d = sample_sel(word_q, wdir_q, 1'b0);
          state_d = PLAY_B;
        end
      end
      PLAY_B: begin
        if (play_step) begin
          audio_d = sample_sel(word_q, wdir_q, 1'b1);
          state_d = FETCH;
          // Comparisons use >= / <= so a start address outside the region
          // wraps on its first step across the boundary.
          if (Direction) begin
            if (addr_q >= LAST_ADDR) begin
              addr_d = FIRST_ADDR;
              term_d = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            if (addr_q <= FIRST_ADDR) begin
              addr_d = LAST_ADDR;
              term_d = 1'b1;
            end else begin
              addr_d = addr_q - 1'b1;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge Rst) begin
    if (!Rst) begin
      state_q <= INIT;
      word_q  <= '0;
      addr_q  <= '0;
      audio_q <= '0;
      wdir_q  <= 1'b1;
      read_q  <= 1'b0;
      term_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      audio_q <= audio_d;
      wdir_q  <= wdir_d;
      read_q  <= read_d;
      term_q  <= term_d;
      tmo_q   <= tmo_d;
    end
  end

  assign AudioData = audio_q;
  assign MEM_ADDR  = addr_q;
  assign Read      = read_q;
  assign Terminate = term_q;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player: a flash responder model plus sample and
// address scoreboards fed by the stimulus sequence.
module tb_music_player;

  localparam logic [22:0] FA = 23'h000000;
  localparam logic [22:0] LA = 23'h07FFFF;

  logic        clk50 = 1'b0;
  logic        clk22 = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] InitialAddress = '0;
  logic        Direction = 1'b1;
  logic        Pause = 1'b0;
  logic [15:0] AudioData;
  logic        Terminate;
  logic [22:0] MEM_ADDR;
  logic        Read;
  logic [31:0] DATA;
  logic        Busy;
  logic        Error;

  int tests = 0;
  int fails = 0;

  logic [15:0] sq[$];
  logic [22:0] aq[$];
  logic        mon_en = 1'b0;
  logic [15:0] last_exp = '0;
  logic [23:0] err_addr = 24'hFFFFFF;
  int          reads_seen = 0;
  int          term_cycles = 0;
  int          term_rises = 0;
  logic        term_prev = 1'b0;

  always #1 clk50 = ~clk50;
  always #20 clk22 = ~clk22;

  music_player #(
    .FIRST_ADDR(FA),
    .LAST_ADDR (LA)
  ) dut (
    .CLK_50M       (clk50),
    .Rst           (rst_n),
    .CLK_22K       (clk22),
    .InitialAddress(InitialAddress),
    .Direction     (Direction),
    .Pause         (Pause),
    .AudioData     (AudioData),
    .Terminate     (Terminate),
    .MEM_ADDR      (MEM_ADDR),
    .Read          (Read),
    .DATA          (DATA),
    .Busy          (Busy),
    .Error         (Error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory word k holds samples 2k (low half) and 2k+1 (high half).
  function automatic logic [31:0] word_of(input logic [22:0] a);
    logic [15:0] lo;
    lo = 16'({a, 1'b0});
    return {lo + 16'd1, lo};
  endfunction

  task automatic push_word(input logic [22:0] a, input logic fwd, input logic err);
    logic [31:0] w;
    w = err ? 32'h0 : word_of(a);
    if (fwd) begin
      sq.push_back(w[15:0]);
      sq.push_back(w[31:16]);
    end else begin
      sq.push_back(w[31:16]);
      sq.push_back(w[15:0]);
    end
    aq.push_back(a);
  endtask

  task automatic hold_reset(input logic [22:0] ia, input logic dir);
    rst_n = 1'b0;
    mon_en = 1'b0;
    sq.delete();
    aq.delete();
    InitialAddress = ia;
    Direction = dir;
    Pause = 1'b0;
    reads_seen = 0;
    term_cycles = 0;
    term_rises = 0;
  endtask

  task automatic release_reset();
    repeat (6) @(negedge clk50);
    @(posedge clk22);
    #3 rst_n = 1'b1;
    @(negedge clk22);
    mon_en = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && sq.size() > 0; i++) @(negedge clk50);
    check({tag, "_samples_left"}, sq.size(), 0);
    check({tag, "_addrs_left"}, aq.size(), 0);
  endtask

  // Flash read controller model: Busy rises half a cycle after Read, data
  // returns four cycles later.
  initial begin
    logic [22:0] a;
    logic [22:0] ea;
    Busy = 1'b0;
    DATA = '0;
    Error = 1'b0;
    forever begin
      @(negedge clk50);
      if (Read === 1'b1) begin
        a = MEM_ADDR;
        reads_seen++;
        if (aq.size() > 0) begin
          ea = aq.pop_front();
          check("mem_addr", a, ea);
        end
        Error = 1'b0;
        Busy = 1'b1;
        repeat (4) @(negedge clk50);
        DATA = word_of(a);
        Error = ({1'b0, a} == err_addr);
        Busy = 1'b0;
      end
    end
  end

  // Sample scoreboard: one comparison per sample-rate edge while enabled.
  initial begin
    logic        p;
    logic [15:0] e;
    forever begin
      @(posedge clk22);
      p = Pause;
      repeat (6) @(negedge clk50);
      if (mon_en) begin
        if (p) begin
          check("pause_hold", AudioData, last_exp);
        end else if (sq.size() > 0) begin
          e = sq.pop_front();
          last_exp = e;
          check("audio", AudioData, e);
        end
      end
    end
  end

  always @(negedge clk50) begin
    if (Terminate) term_cycles++;
    if (Terminate && !term_prev) term_rises++;
    term_prev = Terminate;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and forward run with a mid-word pause.
    hold_reset(23'd0, 1'b1);
    #5;
    check("rst_audio", AudioData, 0);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_read", Read, 0);
    check("rst_term", Terminate, 0);
    for (int k = 0; k < 12; k++) push_word(23'(k), 1'b1, 1'b0);
    release_reset();
    repeat (5) @(posedge clk22);
    @(negedge clk22);
    Pause = 1'b1;
    repeat (5) @(posedge clk22);
    @(negedge clk22);
    check("pause_addr", MEM_ADDR, 2);
    Pause = 1'b0;
    drain("fwd");
    check("fwd_no_term", term_cycles, 0);

    // Backward run.
    hold_reset(23'd5, 1'b0);
    for (int k = 5; k >= 2; k--) push_word(23'(k), 1'b0, 1'b0);
    release_reset();
    drain("bwd");

    // Forward wrap at the top of the region.
    hold_reset(LA, 1'b1);
    push_word(LA, 1'b1, 1'b0);
    push_word(FA, 1'b1, 1'b0);
    push_word(FA + 23'd1, 1'b1, 1'b0);
    release_reset();
    drain("wrapf");
    check("wrapf_term_rises", term_rises, 1);
    check("wrapf_term_cycles", term_cycles, 1);

    // Backward wrap at the bottom of the region.
    hold_reset(FA, 1'b0);
    push_word(FA, 1'b0, 1'b0);
    push_word(LA, 1'b0, 1'b0);
    push_word(LA - 23'd1, 1'b0, 1'b0);
    release_reset();
    drain("wrapb");
    check("wrapb_term_rises", term_rises, 1);
    check("wrapb_term_cycles", term_cycles, 1);

    // Read error on word 3 yields two zero samples.
    err_addr = 24'd3;
    hold_reset(23'd0, 1'b1);
    for (int k = 0; k < 6; k++) push_word(23'(k), 1'b1, k == 3);
    release_reset();
    drain("err");
    err_addr = 24'hFFFFFF;

    // Reset while waiting for read data, then restart from a new address.
    hold_reset(23'd0, 1'b1);
    for (int k = 0; k < 3; k++) push_word(23'(k), 1'b1, 1'b0);
    sq.pop_back();
    sq.pop_back();
    release_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk50);
      if (Busy && reads_seen >= 3) break;
    end
    check("midrd_reached", (Busy && reads_seen >= 3), 1);
    check("midrd_audio_before", AudioData, 3);
    @(negedge clk50);
    hold_reset(23'd9, 1'b1);
    #1;
    check("midrd_read", Read, 0);
    check("midrd_audio", AudioData, 0);
    check("midrd_addr", MEM_ADDR, 0);
    check("midrd_term", Terminate, 0);
    push_word(23'd9, 1'b1, 1'b0);
    push_word(23'd10, 1'b1, 1'b0);
    release_reset();
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/music_player.md
# music_player

- Flash-backed audio sample sequencer.
- Fetches 32-bit words from flash through a read-controller handshake (`MEM_ADDR`/`Read`/`Busy`/`DATA`/`Error`).
- Splits each word into two 16-bit samples and presents one sample on `AudioData` per sample-rate tick.
- Walks the address space forward or backward and flags wrap-around on `Terminate`.
- Sits between the flash read controller and the audio codec interface.

## Interface
Parameters:
- `FIRST_ADDR`, default 23'h000000: lowest word address of the song region.
- `LAST_ADDR`, default 23'h07FFFF: highest word address of the song region.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `CLK_50M`  in  1  system clock; all state is on its rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `CLK_22K`  in  1  sample-rate square wave. Treated as data, not a clock: synchronized into `CLK_50M` and rising-edge detected.
- `InitialAddress`  in  23  start word address, loaded after reset release.
- `Direction`  in  1  1 = forward (ascending), 0 = backward (descending).
- `Pause`  in  1  while high, ticks are ignored and `AudioData` holds.
- `AudioData`  out  16  current sample.
- `Terminate`  out  1  one-cycle pulse on region wrap.
- `MEM_ADDR`  out  23  word address presented to the read controller.
- `Read`  out  1  one-cycle read request.
- `DATA`  in  32  read data; valid when `Busy` falls.
- `Busy`  in  1  read controller busy.
- `Error`  in  1  read controller error; sampled when `Busy` falls.

## Operation
- Reset values: `AudioData`=0, `MEM_ADDR`=0, `Read`=0, `Terminate`=0, state INIT, word register 0.
- Tick: `CLK_22K` passes through a 2-flop synchronizer, then a rising-edge detector, giving a one-cycle `tick`.
- States and transitions:
  - INIT: `MEM_ADDR`<=`InitialAddress`, then go to FETCH.
  - FETCH: `Read`=1 for exactly one cycle (only when `Busy`=0), then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `Busy`=1. If `Busy` has not risen after 16 cycles, return to FETCH (retry).
  - WAIT_DATA: wait for `Busy`=0.
    - Latch `DATA` into the word register, or 32'h0 if `Error`=1.
    - Go to PLAY_A.
  - PLAY_A: on `tick` with `Pause`=0, output the first sample, then go to PLAY_B.
  - PLAY_B: on `tick` with `Pause`=0, output the second sample, advance `MEM_ADDR`, then go to FETCH.
- Sample order is fixed by `Direction` sampled at latch time:
  - forward: `DATA[15:0]` first, then `DATA[31:16]`;
  - backward: `DATA[31:16]` first, then `DATA[15:0]`.
- Address advance uses `Direction` sampled at the PLAY_B tick:
  - forward: +1; `LAST_ADDR` wraps to `FIRST_ADDR`;
  - backward: -1; `FIRST_ADDR` wraps to `LAST_ADDR`.
  - A wrap pulses `Terminate` in the same cycle as the address update.
- An `InitialAddress` outside [`FIRST_ADDR`,`LAST_ADDR`] is used as is. The first boundary crossing in the current direction then wraps.
- A tick arriving during FETCH/WAIT_* is dropped: the sample underruns and `AudioData` holds. At the 20:1 clock ratio a read must finish within about 18 cycles so no ticks are lost.
- `Pause` does not block fetches. Only the PLAY_* transitions are frozen.
- `Rst` asserted mid-read: all outputs return to reset values immediately and `Read` drops asynchronously.

## Timing
- `tick` is asserted 3 `CLK_50M` cycles after the `CLK_22K` rising edge.
- `AudioData` updates on the cycle after `tick`.
- `MEM_ADDR` is stable from the `Read` cycle until `Busy` falls.
- From `Busy` falling to the word register updated: 1 cycle.
- `Terminate`: high exactly 1 cycle per wrap.

## Structure
- Package `music_player_pkg` holds:
  - `ADDR_W`=23, `WORD_W`=32, `SAMPLE_W`=16;
  - state enum `mp_state_t` {INIT, FETCH, WAIT_BUSY, WAIT_DATA, PLAY_A, PLAY_B};
  - `BUSY_TIMEOUT`=16.
- Sub-module `tick_sync`: 2-flop synchronizer plus rising-edge detector producing `tick`.
- Everything else lives in one FSM module, with the datapath registers `word_q`, `addr_q` and `audio_q`.

## Test plan
- Normal forward run:
  - setup: `CLK_50M` period 2, `CLK_22K` period 40, `InitialAddress`=0, `Direction`=1, memory word k = {16'(2k+1), 16'(2k)};
  - response: `AudioData` sequence 0,1,2,3,…; `MEM_ADDR` 0,1,2…; exactly one `Read` per two ticks; 1000 time units with no underrun.
- Backward run:
  - setup: `InitialAddress`=5, `Direction`=0;
  - response: `AudioData` 11,10,9,8,…; `MEM_ADDR` 5,4,3…
- Wrap:
  - setup: `InitialAddress`=`LAST_ADDR`, forward;
  - response: after 2 samples `MEM_ADDR`=`FIRST_ADDR` and `Terminate` is high for 1 cycle. Repeat backward from `FIRST_ADDR` and require `MEM_ADDR`=`LAST_ADDR`.
- Pause:
  - stimulus: `Pause`=1 for 5 ticks mid-word;
  - response: `AudioData` is constant and no address advance. After release, the sequence resumes with no skipped sample.
- Error:
  - stimulus: `Error`=1 when `Busy` falls on word 3;
  - response: samples 6 and 7 are output as 0, then the sequence continues with 8.
- Reset mid-read:
  - stimulus: `Rst`=0 while in WAIT_DATA;
  - response: `Read`/`AudioData`/`MEM_ADDR`=0 immediately. After release, playback restarts at `InitialAddress`.
